aes_round_sequencer_visc: RTL and testbench

Iterative AES-128 encryption controller. It time-multiplexes one shared round datapath across all rounds of a block: the registered SubBytes/ShiftRows/MixColumns middle-round unit and the last-round unit (SubBytes, ShiftRows, AddRoundKey, no MixColumns). It sits between the accelerator FIFO interface (valid/ready) and the round datapath. It fetches round keys by index from an external key store, performs the initial AddRoundKey, and sequences NUM_ROUNDS rounds, selecting the last-round path for the final round.

---
 rtl/aes_round_sequencer_visc_if.sv | 36 +++
 rtl/aes_round_sequencer_visc.sv | 123 ++++++++++++
 tb/tb_aes_round_sequencer_visc.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_sequencer_visc_if.sv
// Bundle of every non-clock signal of the AES round sequencer.
//   in_*        : plaintext stream from the accelerator FIFO (valid/ready)
//   out_*       : ciphertext stream to the consumer (valid/ready)
//   rk_idx/data : round-key lookup, rk_data combinational on rk_idx
//   rnd_*       : shared round datapath (state/key out, selected result in)
//   busy        : block in flight
//   round_cnt   : current round number, 0 when idle
// master = the sequencer; slave = its environment (FIFOs, key store, datapath).
interface aes_round_sequencer_visc_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic [127:0] rnd_data;
   logic [127:0] rnd_key;
   logic         rnd_last;
   logic [127:0] rnd_result;
   logic         busy;
   logic [3:0]   round_cnt;

   modport master (
      input  in_valid, in_data, out_ready, rk_data, rnd_result,
      output in_ready, out_valid, out_data, rk_idx, rnd_data, rnd_key, rnd_last,
             busy, round_cnt
   );

   modport slave (
      output in_valid, in_data, out_ready, rk_data, rnd_result,
      input  in_ready, out_valid, out_data, rk_idx, rnd_data, rnd_key, rnd_last,
             busy, round_cnt
   );
endinterface

// File: rtl/aes_round_sequencer_visc.sv
// Iterative AES-128 encryption controller. Accepts one plaintext block, performs
// the initial AddRoundKey, then drives the shared round datapath once per round,
// waiting RoundLat cycles for each result and flagging the final round so the
// datapath selects its no-MixColumns path.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : master side of aes_round_sequencer_visc_if (streams, key store,
//           round datapath, status)
module aes_round_sequencer_visc #(
   parameter int unsigned NumRounds = 10,
   parameter int unsigned RoundLat  = 2
) (
   input logic                               clk,
   input logic                               rst_n,
   aes_round_sequencer_visc_if.master        bus
);

   localparam int unsigned CntW      = (RoundLat > 1) ? $clog2(RoundLat + 1) : 1;
   localparam logic [3:0]  LastRound = 4'(NumRounds);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   state_e              state_q, state_d;
   logic [127:0]        blk_q, blk_d;
   logic [127:0]        rnd_data_q, rnd_data_d;
   logic [127:0]        rnd_key_q, rnd_key_d;
   logic                rnd_last_q, rnd_last_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [3:0]          round_q, round_d;
   logic                out_valid_q, out_valid_d;
   logic [127:0]        out_data_q, out_data_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         blk_q       <= '0;
         rnd_data_q  <= '0;
         rnd_key_q   <= '0;
         rnd_last_q  <= 1'b0;
         cnt_q       <= '0;
         round_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         blk_q       <= blk_d;
         rnd_data_q  <= rnd_data_d;
         rnd_key_q   <= rnd_key_d;
         rnd_last_q  <= rnd_last_d;
         cnt_q       <= cnt_d;
         round_q     <= round_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      blk_d       = blk_q;
      rnd_data_d  = rnd_data_q;
      rnd_key_d   = rnd_key_q;
      rnd_last_d  = rnd_last_q;
      cnt_d       = cnt_q;
      round_d     = round_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      unique case (state_q)
         StIdle: begin
            // in_ready is high throughout idle, so valid alone completes the handshake
            if (bus.in_valid) begin
               blk_d   = bus.in_data ^ bus.rk_data;
               round_d = 4'd1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            rnd_data_d = blk_q;
            rnd_key_d  = bus.rk_data;
            rnd_last_d = (round_q == LastRound);
            cnt_d      = CntW'(RoundLat);
            state_d    = StWait;
         end
         StWait: begin
            // rnd_* stay frozen here: the last-round key add is combinational on rnd_key
            if (cnt_q == CntW'(1)) begin
               blk_d = bus.rnd_result;
               if (round_q == LastRound) begin
                  out_data_d  = bus.rnd_result;
                  out_valid_d = 1'b1;
                  rnd_last_d  = 1'b0;
                  state_d     = StDone;
               end else begin
                  round_d = round_q + 4'd1;
                  state_d = StIssue;
               end
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               round_d     = '0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.busy      = (state_q != StIdle);
   assign bus.rk_idx    = (state_q == StIdle) ? 4'd0 : round_q;
   assign bus.round_cnt = round_q;
   assign bus.rnd_data  = rnd_data_q;
   assign bus.rnd_key   = rnd_key_q;
   assign bus.rnd_last  = rnd_last_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_aes_round_sequencer_visc.sv
// Directed bench for aes_round_sequencer_visc: key store built by AES key
// expansion, a behavioural round datapath with one registered stage, a vector
// table of known-answer blocks, plus back-to-back and mid-block reset sequences.
module tb_aes_round_sequencer_visc;

   localparam int NR = 10;

   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
      int           hold;   // cycles of out_ready=0 after out_valid rises
      logic         poke;   // drive junk in_valid while busy
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   logic [7:0]   sbox [256];
   logic [127:0] ks   [16];
   logic [127:0] sb_q;

   aes_round_sequencer_visc_if bus_if ();

   aes_round_sequencer_visc #(
      .NumRounds (NR),
      .RoundLat  (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- AES reference helpers ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = b;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h01;
         for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(a));
         if (a == 0) inv = 8'h00;
         sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                   ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
      return o;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
         o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
      return o;
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
      logic [127:0] sr;
      sr = shift_rows(sub_bytes(s));
      return (last ? sr : mix_columns(sr)) ^ k;
   endfunction

   task automatic load_keys(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++) begin
         if (r <= NR) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         else         ks[r] = '0;
      end
   endtask

   // ---------------- environment: key store and round datapath ----------------
   assign bus_if.rk_data = ks[bus_if.rk_idx];

   // Sub-bytes is registered; shift-rows, mix-columns and key add settle
   // combinationally, so the result is good on the second WAIT cycle only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sb_q <= '0;
      else        sb_q <= sub_bytes(bus_if.rnd_data);
   end

   assign bus_if.rnd_result = (bus_if.rnd_last ? shift_rows(sb_q)
                                               : mix_columns(shift_rows(sb_q)))
                              ^ bus_if.rnd_key;

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_in_ready"},  128'(bus_if.in_ready),  128'(1));
      chk({tag, "_out_valid"}, 128'(bus_if.out_valid), 128'(0));
      chk({tag, "_out_data"},  bus_if.out_data,        128'(0));
      chk({tag, "_rnd_data"},  bus_if.rnd_data,        128'(0));
      chk({tag, "_rnd_key"},   bus_if.rnd_key,         128'(0));
      chk({tag, "_rnd_last"},  128'(bus_if.rnd_last),  128'(0));
      chk({tag, "_rk_idx"},    128'(bus_if.rk_idx),    128'(0));
      chk({tag, "_round_cnt"}, 128'(bus_if.round_cnt), 128'(0));
      chk({tag, "_busy"},      128'(bus_if.busy),      128'(0));
   endtask

   // One block from acceptance through output handshake, checking every cycle.
   task automatic run_block(input vec_t v);
      logic [127:0] st;
      int           r;
      int           ph;
      load_keys(v.key);
      @(negedge clk);
      chk("idle_in_ready", 128'(bus_if.in_ready), 128'(1));
      chk("idle_rk_idx",   128'(bus_if.rk_idx),   128'(0));
      chk("idle_busy",     128'(bus_if.busy),     128'(0));
      bus_if.in_valid  = 1'b1;
      bus_if.in_data   = v.pt;
      bus_if.out_ready = (v.hold == 0);
      st = v.pt ^ ks[0];
      @(posedge clk);
      #1;
      bus_if.in_valid = v.poke;
      bus_if.in_data  = ~v.pt;
      for (int k = 1; k <= 31; k++) begin
         @(negedge clk);
         r  = (k - 1) / 3 + 1;
         ph = (k - 1) % 3;
         if (k < 31) begin
            chk("busy",        128'(bus_if.busy),      128'(1));
            chk("in_ready",    128'(bus_if.in_ready),  128'(0));
            chk("early_valid", 128'(bus_if.out_valid), 128'(0));
            chk("round_cnt",   128'(bus_if.round_cnt), 128'(r));
            if (ph == 0) begin
               chk("rk_idx", 128'(bus_if.rk_idx), 128'(r));
            end else begin
               chk("rnd_key",  bus_if.rnd_key,          ks[r]);
               chk("rnd_last", 128'(bus_if.rnd_last),   128'(r == NR));
               chk("rnd_data", bus_if.rnd_data,         st);
               if (ph == 2) st = aes_round(st, ks[r], r == NR);
            end
         end else begin
            chk("latency_valid", 128'(bus_if.out_valid), 128'(1));
            chk("ciphertext",    bus_if.out_data,        v.ct);
         end
      end
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         chk("bp_valid",    128'(bus_if.out_valid), 128'(1));
         chk("bp_data",     bus_if.out_data,        v.ct);
         chk("bp_in_ready", 128'(bus_if.in_ready),  128'(0));
         chk("bp_busy",     128'(bus_if.busy),      128'(1));
      end
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_if.in_valid = 1'b0;
      @(negedge clk);
      chk("post_valid",    128'(bus_if.out_valid), 128'(0));
      chk("post_in_ready", 128'(bus_if.in_ready),  128'(1));
      chk("post_busy",     128'(bus_if.busy),      128'(0));
      chk("post_round",    128'(bus_if.round_cnt), 128'(0));
   endtask

   // ---------------- stimulus ----------------
   localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;

   vec_t vecs [4];
   int   nvalid;
   int   first_k;
   int   second_k;

   initial begin
      n_checks          = 0;
      n_errors          = 0;
      rst_n             = 1'b0;
      bus_if.in_valid   = 1'b0;
      bus_if.in_data    = '0;
      bus_if.out_ready  = 1'b0;

      vecs[0] = '{key: KeyB, pt: 128'h3243f6a8885a308d313198a2e0370734,
                  ct: 128'h3925841d02dc09fbdc118597196a0b32, hold: 0, poke: 1'b0};
      vecs[1] = '{key: KeyB, pt: 128'h6bc1bee22e409f96e93d7e117393172a,
                  ct: 128'h3ad77bb40d7a3660a89ecaf32466ef97, hold: 3, poke: 1'b1};
      vecs[2] = '{key: KeyC1, pt: 128'h00112233445566778899aabbccddeeff,
                  ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, hold: 0, poke: 1'b0};
      vecs[3] = '{key: KeyB, pt: 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                  ct: 128'hf5d3d58503b9699de785895a96fdbaaf, hold: 20, poke: 1'b1};

      build_sbox();
      load_keys(KeyB);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset("reset");

      for (int i = 0; i < 4; i++) run_block(vecs[i]);

      // Back-to-back: in_valid held high for two C.1 blocks.
      load_keys(KeyC1);
      nvalid   = 0;
      first_k  = -1;
      second_k = -1;
      @(negedge clk);
      bus_if.in_valid  = 1'b1;
      bus_if.in_data   = vecs[2].pt;
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 70; k++) begin
         @(negedge clk);
         if (k == 32) chk("b2b_idle_gap", 128'(bus_if.in_ready), 128'(1));
         if (k == 33) bus_if.in_valid = 1'b0;
         if (bus_if.out_valid) begin
            nvalid++;
            if (nvalid == 1) first_k = k;
            if (nvalid == 2) second_k = k;
            chk("b2b_ct", bus_if.out_data, vecs[2].ct);
         end
      end
      chk("b2b_count",  128'(nvalid),   128'(2));
      chk("b2b_first",  128'(first_k),  128'(31));
      chk("b2b_second", 128'(second_k), 128'(63));

      // Reset in the middle of round 5.
      load_keys(KeyB);
      @(negedge clk);
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = vecs[0].pt;
      @(posedge clk);
      #1;
      bus_if.in_valid = 1'b0;
      repeat (14) @(negedge clk);
      chk("pre_reset_round", 128'(bus_if.round_cnt), 128'(5));
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("async_reset");
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      nvalid = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus_if.out_valid) nvalid++;
      end
      chk("no_output_after_reset", 128'(nvalid), 128'(0));
      run_block(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
